// File: rtl/adsr_envelope_if.sv
// Control/status bundle between the Core and one ADSR envelope voice.
// master = Core side (drives note and shape controls), slave = envelope voice.
interface adsr_envelope_if;
  logic        gate;
  logic [15:0] peak_level;
  logic [7:0]  attack_rate;
  logic [7:0]  decay_rate;
  logic [7:0]  sustain_lvl;
  logic [7:0]  release_rate;
  logic [15:0] pwm_reg;
  logic [2:0]  env_state;
  logic        busy;

  modport master (
    output gate, peak_level, attack_rate, decay_rate, sustain_lvl, release_rate,
    input  pwm_reg, env_state, busy
  );

  modport slave (
    input  gate, peak_level, attack_rate, decay_rate, sustain_lvl, release_rate,
    output pwm_reg, env_state, busy
  );
endinterface

// File: rtl/adsr_envelope.sv
// Per-voice ADSR amplitude envelope: scales the Core's peak duty word by a 16-bit envelope.
// Optional build macro ENV_HARD_RETRIG_EN: a note-on restarts the attack from zero.
module adsr_envelope #(
  parameter int unsigned PRESCALE = 256
) (
  input  logic           clk,
  input  logic           reset,
  adsr_envelope_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  localparam logic [31:0] PRESC_LAST = 32'(PRESCALE - 1);

  state_e      state_q, state_d;
  logic [15:0] env_q, env_d;
  logic [15:0] pwm_reg_q, pwm_reg_d;
  logic        busy_q, busy_d;
  logic [31:0] presc_q, presc_d;
  logic        gate_dly_q, gate_dly_d;
  logic        armed_q, armed_d;

  logic        tick_s;
  logic        rise_s;
  logic        fall_s;
  state_e      eff_state_s;
  logic [15:0] base_s;
  logic [15:0] step_s;
  logic [15:0] sus_env_s;
  logic [16:0] sum_s;
  logic [16:0] diff_s;
  logic [31:0] product_s;

  // Free-running envelope prescaler.
  always_comb begin
    tick_s = (presc_q == PRESC_LAST);
    if (tick_s) begin
      presc_d = 32'd0;
    end else begin
      presc_d = presc_q + 32'd1;
    end
  end

  // Gate edge detection; a gate already high when reset releases is not a note-on.
  always_comb begin
    gate_dly_d = bus.gate;
    armed_d    = armed_q | ~bus.gate;
    rise_s     = bus.gate & ~gate_dly_q & armed_q;
    fall_s     = ~bus.gate & gate_dly_q;
  end

  // Envelope next-state and level update.
  always_comb begin
    state_d     = state_q;
    env_d       = env_q;
    sus_env_s   = {bus.sustain_lvl, 8'h00};
    eff_state_s = state_q;
    base_s      = env_q;

    if (rise_s) begin
      eff_state_s = ST_ATTACK;
      state_d     = ST_ATTACK;
`ifdef ENV_HARD_RETRIG_EN
      base_s      = 16'h0000;
`else
      base_s      = env_q;
`endif
    end else begin
      eff_state_s = state_q;
      base_s      = env_q;
    end

    // A rise coinciding with a tick already steps with attack rules here.
    case (eff_state_s)
      ST_ATTACK:  step_s = {bus.attack_rate, 8'h00};
      ST_DECAY:   step_s = {bus.decay_rate, 8'h00};
      ST_RELEASE: step_s = {bus.release_rate, 8'h00};
      default:    step_s = 16'h0000;
    endcase

    sum_s  = {1'b0, base_s} + {1'b0, step_s};
    diff_s = {1'b0, base_s} - {1'b0, step_s};

    if (fall_s && (state_q != ST_IDLE)) begin
      state_d = ST_RELEASE;
      env_d   = env_q;
    end else begin
      case (eff_state_s)
        ST_ATTACK: begin
          if (tick_s && (step_s != 16'h0000)) begin
            if (sum_s >= 17'h0FFFF) begin
              env_d   = 16'hFFFF;
              state_d = ST_DECAY;
            end else begin
              env_d   = sum_s[15:0];
            end
          end else begin
            env_d = base_s;
          end
        end
        ST_DECAY: begin
          if (tick_s && (step_s != 16'h0000)) begin
            if (diff_s[16] || (diff_s[15:0] <= sus_env_s)) begin
              env_d   = sus_env_s;
              state_d = ST_SUSTAIN;
            end else begin
              env_d   = diff_s[15:0];
            end
          end else begin
            env_d = env_q;
          end
        end
        ST_SUSTAIN: begin
          env_d = sus_env_s;
        end
        ST_RELEASE: begin
          if (tick_s && (step_s != 16'h0000)) begin
            if (diff_s[16] || (diff_s[15:0] == 16'h0000)) begin
              env_d   = 16'h0000;
              state_d = ST_IDLE;
            end else begin
              env_d   = diff_s[15:0];
            end
          end else begin
            env_d = env_q;
          end
        end
        default: begin
          env_d = env_q;
        end
      endcase
    end
  end

  // Output scaling: upper half of peak * env.
  always_comb begin
    product_s = 32'(bus.peak_level) * 32'(env_q);
    pwm_reg_d = 16'(product_s >> 16);
    busy_d    = (state_d != ST_IDLE);
  end

  // State, envelope, prescaler and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      env_q      <= 16'h0000;
      pwm_reg_q  <= 16'h0000;
      busy_q     <= 1'b0;
      presc_q    <= 32'd0;
      gate_dly_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      env_q      <= env_d;
      pwm_reg_q  <= pwm_reg_d;
      busy_q     <= busy_d;
      presc_q    <= presc_d;
      gate_dly_q <= gate_dly_d;
      armed_q    <= armed_d;
    end
  end

  assign bus.pwm_reg   = pwm_reg_q;
  assign bus.env_state = state_q;
  assign bus.busy      = busy_q;

endmodule
